// File: rtl/oct_reg_arbiter_pkg.sv
// Shared constants for the octal-register arbiter: FSM encoding, op codes and
// timing defaults derived from the FF bank's propagation delay.
package oct_reg_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_LOAD   = 2'd1;
   localparam state_t S_SETTLE = 2'd2;
   localparam state_t S_DONE   = 2'd3;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   localparam int CLK_PERIOD_NS = 20;
   localparam int REG_TPD_NS    = 48;

   // Whole clock cycles needed to cover a propagation delay.
   function automatic int settle_cycles(input int tpd_ns, input int clk_ns);
      return (tpd_ns + clk_ns - 1) / clk_ns;
   endfunction

   localparam int SETTLE_DEFAULT = settle_cycles(REG_TPD_NS, CLK_PERIOD_NS);

endpackage

// File: rtl/oct_reg_arbiter_if.sv
// Requester and register-bank bus of the octal-register arbiter.
// The master side is the board (requesters + FF bank), the slave side is the arbiter.
interface oct_reg_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
);

   logic [NREQ-1:0]       REQ;
   logic [NREQ-1:0]       OP;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [NREQ-1:0]       GNT;
   logic                  ACK;
   logic                  BUSY;
   logic [WIDTH-1:0]      REG_D;
   logic                  REG_LD;
   logic                  REG_NCLR;
   logic [WIDTH-1:0]      REG_Q;
   logic [CNTW-1:0]       RISE_CNT;

   modport master (
      output REQ, OP, DIN, REG_Q,
      input  GNT, ACK, BUSY, REG_D, REG_LD, REG_NCLR, RISE_CNT
   );

   modport slave (
      input  REQ, OP, DIN, REG_Q,
      output GNT, ACK, BUSY, REG_D, REG_LD, REG_NCLR, RISE_CNT
   );

endinterface

// File: rtl/oct_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo NREQ, returned one-hot with a valid flag.
module oct_reg_arbiter_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_oh,
   output logic            valid
);

   logic [PW-1:0] cand;

   always_comb begin
      gnt_oh = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = PW'((32'(ptr) + off) % NREQ);
         if (!valid && req[cand]) begin
            gnt_oh[cand] = 1'b1;
            valid        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oct_reg_arbiter.sv
// Round-robin controller sharing one octal FF bank between NREQ requesters,
// with a saturating count of 0->1 transitions on the register outputs.
module oct_reg_arbiter
   import oct_reg_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 8,
   parameter int SETTLE = SETTLE_DEFAULT,
   parameter int CNTW   = 16
) (
   input  logic             CLK,
   input  logic             CLR,
   oct_reg_arbiter_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WW-1:0] WAIT_INIT = (SETTLE > 0) ? WW'(SETTLE - 1) : '0;
   localparam int RW = $clog2(WIDTH + 1);
   localparam int SW = ((CNTW > RW) ? CNTW : RW) + 1;
   localparam logic [SW-1:0] CNT_MAX = SW'({CNTW{1'b1}});

   state_t           state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    idx_l;
   logic             op_l;
   logic [WIDTH-1:0] data_l;
   logic [WW-1:0]    wait_cnt;

   logic [NREQ-1:0]  gnt;
   logic             ack;
   logic             busy;
   logic [WIDTH-1:0] reg_d;
   logic             reg_ld;
   logic             reg_nclr;

   logic [NREQ-1:0]  pick_oh;
   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic             pick_op;
   logic [WIDTH-1:0] pick_data;

   logic [WIDTH-1:0] q_prev;
   logic [CNTW-1:0]  rise_cnt;
   logic [RW-1:0]    rises;
   logic [SW-1:0]    sum;

   oct_reg_arbiter_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req    (bus.REQ),
      .ptr    (rr_ptr),
      .gnt_oh (pick_oh),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx  = '0;
      pick_op   = OP_LOAD;
      pick_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_oh[i]) begin
            pick_idx  = PW'(i);
            pick_op   = bus.OP[i];
            pick_data = bus.DIN[i*WIDTH +: WIDTH];
         end
      end
   end

   // Outputs are registered from the current state, so each strobe trails
   // the state it belongs to by one edge; GNT/BUSY bridge back-to-back grants.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         idx_l    <= '0;
         op_l     <= OP_LOAD;
         data_l   <= '0;
         wait_cnt <= '0;
         gnt      <= '0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         reg_d    <= '0;
         reg_ld   <= 1'b0;
         reg_nclr <= 1'b1;
      end else begin
         ack      <= 1'b0;
         reg_ld   <= 1'b0;
         reg_nclr <= 1'b1;
         case (state)
            S_IDLE: begin
               gnt  <= pick_oh;
               busy <= pick_valid;
               if (pick_valid) begin
                  idx_l  <= pick_idx;
                  op_l   <= pick_op;
                  data_l <= pick_data;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               reg_ld   <= 1'b1;
               reg_nclr <= (op_l != OP_CLEAR);
               reg_d    <= (op_l == OP_LOAD) ? data_l : '0;
               wait_cnt <= WAIT_INIT;
               state    <= (SETTLE == 0) ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
               if (wait_cnt == '0) state <= S_DONE;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            default: begin
               ack    <= 1'b1;
               rr_ptr <= (idx_l == PW'(NREQ - 1)) ? '0 : idx_l + 1'b1;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rises = '0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
         rises = rises + RW'(bus.REG_Q[b] & ~q_prev[b]);
      end
   end

   assign sum = SW'(rise_cnt) + SW'(rises);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         q_prev   <= '0;
         rise_cnt <= '0;
      end else begin
         q_prev   <= bus.REG_Q;
         rise_cnt <= (sum > CNT_MAX) ? CNTW'(CNT_MAX) : CNTW'(sum);
      end
   end

   assign bus.GNT      = gnt;
   assign bus.ACK      = ack;
   assign bus.BUSY     = busy;
   assign bus.REG_D    = reg_d;
   assign bus.REG_LD   = reg_ld;
   assign bus.REG_NCLR = reg_nclr;
   assign bus.RISE_CNT = rise_cnt;

endmodule

// File: tb/tb_oct_reg_arbiter.sv
// Directed bench for oct_reg_arbiter: a SETTLE=3 build and a SETTLE=0/CNTW=4 build,
// each behind an 8-bit FF bank with asynchronous clear and 48-unit output delay.
module tb_oct_reg_arbiter;
   import oct_reg_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic clk   = 1'b0;
   logic clr_a = 1'b1;
   logic clr_b = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #(CLK_PERIOD_NS / 2) clk = ~clk;

   oct_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(16)) bus_a ();
   oct_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(4))  bus_b ();

   oct_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(3), .CNTW(16)) u_a (
      .CLK (clk),
      .CLR (clr_a),
      .bus (bus_a)
   );

   oct_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(0), .CNTW(4)) u_b (
      .CLK (clk),
      .CLR (clr_b),
      .bus (bus_b)
   );

   logic [WIDTH-1:0] qa = '0;
   logic [WIDTH-1:0] qb = '0;

   always @(posedge clk or negedge bus_a.REG_NCLR)
      if (!bus_a.REG_NCLR)   qa <= '0;
      else if (bus_a.REG_LD) qa <= bus_a.REG_D;

   always @(posedge clk or negedge bus_b.REG_NCLR)
      if (!bus_b.REG_NCLR)   qb <= '0;
      else if (bus_b.REG_LD) qb <= bus_b.REG_D;

   assign #REG_TPD_NS bus_a.REG_Q = qa;
   assign #REG_TPD_NS bus_b.REG_Q = qb;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic b_load(input logic [WIDTH-1:0] d);
      bus_b.DIN = {24'h0, d};
      bus_b.REQ = 4'b0001;
      tick(1);
      bus_b.REQ = '0;
      tick(6);
   endtask

   initial begin
      bus_a.REQ = '0; bus_a.OP = '0; bus_a.DIN = '0;
      bus_b.REQ = '0; bus_b.OP = '0; bus_b.DIN = '0;
      tick(2);

      chk("rst_gnt",  32'(bus_a.GNT), 32'h0);
      chk("rst_ack",  32'(bus_a.ACK), 32'h0);
      chk("rst_busy", 32'(bus_a.BUSY), 32'h0);
      chk("rst_d",    32'(bus_a.REG_D), 32'h0);
      chk("rst_ld",   32'(bus_a.REG_LD), 32'h0);
      chk("rst_nclr", 32'(bus_a.REG_NCLR), 32'h1);
      chk("rst_rise", 32'(bus_a.RISE_CNT), 32'h0);

      clr_a = 1'b0;
      tick(2);
      chk("idle_busy", 32'(bus_a.BUSY), 32'h0);
      chk("idle_gnt",  32'(bus_a.GNT), 32'h0);
      chk("idle_ld",   32'(bus_a.REG_LD), 32'h0);

      // single load from requester 1; late REQ/OP/DIN changes must be ignored
      bus_a.DIN = {8'h77, 8'h66, 8'hA5, 8'h11};
      bus_a.REQ = 4'b0010;
      tick(1);
      chk("s_gnt",  32'(bus_a.GNT), 32'h2);
      chk("s_busy", 32'(bus_a.BUSY), 32'h1);
      chk("s_ld0",  32'(bus_a.REG_LD), 32'h0);
      bus_a.REQ = '0; bus_a.OP = 4'b0010; bus_a.DIN = '0;
      tick(1);
      chk("s_ld",   32'(bus_a.REG_LD), 32'h1);
      chk("s_d",    32'(bus_a.REG_D), 32'hA5);
      chk("s_nclr", 32'(bus_a.REG_NCLR), 32'h1);
      tick(1);
      chk("s_ld_off", 32'(bus_a.REG_LD), 32'h0);
      chk("s_d_hold", 32'(bus_a.REG_D), 32'hA5);
      tick(2);
      chk("s_ack_early", 32'(bus_a.ACK), 32'h0);
      chk("s_rise_pre",  32'(bus_a.RISE_CNT), 32'h0);
      tick(1);
      chk("s_ack",      32'(bus_a.ACK), 32'h1);
      chk("s_gnt_done", 32'(bus_a.GNT), 32'h2);
      chk("s_q",        32'(bus_a.REG_Q), 32'hA5);
      chk("s_rise",     32'(bus_a.RISE_CNT), 32'h4);
      tick(1);
      chk("s_ack_off",  32'(bus_a.ACK), 32'h0);
      chk("s_gnt_off",  32'(bus_a.GNT), 32'h0);
      chk("s_busy_off", 32'(bus_a.BUSY), 32'h0);
      bus_a.OP = '0;

      // contention 1011 from rr_ptr=0; register still holds A5 after reset
      clr_a = 1'b1;
      tick(1);
      chk("c_rst_rise", 32'(bus_a.RISE_CNT), 32'h0);
      bus_a.DIN = {8'h3C, 8'h00, 8'hF0, 8'h0F};
      bus_a.REQ = 4'b1011;
      clr_a = 1'b0;
      tick(1);
      chk("c_gnt0",     32'(bus_a.GNT), 32'h1);
      chk("c_rise_rel", 32'(bus_a.RISE_CNT), 32'h4);
      tick(5);
      chk("c_ack0",  32'(bus_a.ACK), 32'h1);
      chk("c_busy0", 32'(bus_a.BUSY), 32'h1);
      chk("c_rise0", 32'(bus_a.RISE_CNT), 32'h6);
      tick(1);
      chk("c_gnt1",      32'(bus_a.GNT), 32'h2);
      chk("c_busy_held", 32'(bus_a.BUSY), 32'h1);
      chk("c_ack0_off",  32'(bus_a.ACK), 32'h0);
      tick(5);
      chk("c_ack1",  32'(bus_a.ACK), 32'h1);
      chk("c_rise1", 32'(bus_a.RISE_CNT), 32'd10);
      tick(1);
      chk("c_gnt3", 32'(bus_a.GNT), 32'h8);
      tick(5);
      chk("c_ack3",  32'(bus_a.ACK), 32'h1);
      chk("c_rise3", 32'(bus_a.RISE_CNT), 32'd12);
      tick(1);
      chk("c_gnt0b", 32'(bus_a.GNT), 32'h1);
      bus_a.REQ = '0;
      tick(5);
      chk("c_ack0b",  32'(bus_a.ACK), 32'h1);
      chk("c_d0b",    32'(bus_a.REG_D), 32'h0F);
      chk("c_rise0b", 32'(bus_a.RISE_CNT), 32'd14);
      tick(1);
      chk("c_busy_drop", 32'(bus_a.BUSY), 32'h0);
      chk("c_gnt_drop",  32'(bus_a.GNT), 32'h0);

      // clear op: first fill with FF via requester 2, then clear through it
      bus_a.DIN = {8'h00, 8'hFF, 8'h00, 8'h00};
      bus_a.REQ = 4'b0100;
      tick(1);
      chk("f_gnt", 32'(bus_a.GNT), 32'h4);
      bus_a.REQ = '0;
      tick(6);
      chk("f_q",    32'(bus_a.REG_Q), 32'hFF);
      chk("f_rise", 32'(bus_a.RISE_CNT), 32'd18);
      bus_a.REQ = 4'b0100;
      bus_a.OP  = 4'b0100;
      tick(1);
      chk("x_gnt", 32'(bus_a.GNT), 32'h4);
      bus_a.REQ = '0; bus_a.OP = '0;
      tick(1);
      chk("x_nclr", 32'(bus_a.REG_NCLR), 32'h0);
      chk("x_ld",   32'(bus_a.REG_LD), 32'h1);
      chk("x_d",    32'(bus_a.REG_D), 32'h00);
      tick(1);
      chk("x_nclr_rel", 32'(bus_a.REG_NCLR), 32'h1);
      tick(3);
      chk("x_ack",  32'(bus_a.ACK), 32'h1);
      chk("x_q",    32'(bus_a.REG_Q), 32'h00);
      chk("x_rise", 32'(bus_a.RISE_CNT), 32'd18);
      tick(1);

      // reset mid-SETTLE; 1001 pending would pick 3 if rr_ptr survived
      bus_a.DIN = {8'h00, 8'h00, 8'hC3, 8'h00};
      bus_a.REQ = 4'b0010;
      tick(1);
      chk("r_gnt", 32'(bus_a.GNT), 32'h2);
      bus_a.REQ = 4'b1001;
      tick(2);
      #5;
      clr_a = 1'b1;
      #1;
      chk("r_gnt_async",  32'(bus_a.GNT), 32'h0);
      chk("r_busy_async", 32'(bus_a.BUSY), 32'h0);
      chk("r_ack_async",  32'(bus_a.ACK), 32'h0);
      chk("r_nclr_async", 32'(bus_a.REG_NCLR), 32'h1);
      tick(3);
      chk("r_ack_held", 32'(bus_a.ACK), 32'h0);
      clr_a = 1'b0;
      tick(1);
      chk("r_regrant", 32'(bus_a.GNT), 32'h1);
      bus_a.REQ = '0;
      tick(5);
      chk("r_ack_after", 32'(bus_a.ACK), 32'h1);

      // SETTLE=0, CNTW=4 build
      chk("b_rst_gnt",  32'(bus_b.GNT), 32'h0);
      chk("b_rst_rise", 32'(bus_b.RISE_CNT), 32'h0);
      clr_b = 1'b0;
      tick(1);
      bus_b.DIN = {24'h0, 8'hFF};
      bus_b.REQ = 4'b0001;
      tick(1);
      chk("b_gnt", 32'(bus_b.GNT), 32'h1);
      bus_b.REQ = '0;
      tick(1);
      chk("b_ld",        32'(bus_b.REG_LD), 32'h1);
      chk("b_ack_early", 32'(bus_b.ACK), 32'h0);
      tick(1);
      chk("b_ack",      32'(bus_b.ACK), 32'h1);
      chk("b_gnt_done", 32'(bus_b.GNT), 32'h1);
      tick(1);
      chk("b_ack_off", 32'(bus_b.ACK), 32'h0);
      chk("b_gnt_off", 32'(bus_b.GNT), 32'h0);
      tick(3);
      chk("b_rise8", 32'(bus_b.RISE_CNT), 32'd8);
      b_load(8'h00);
      chk("b_fall_ignored", 32'(bus_b.RISE_CNT), 32'd8);
      b_load(8'hFF);
      chk("b_sat", 32'(bus_b.RISE_CNT), 32'd15);
      b_load(8'h00);
      b_load(8'hFF);
      chk("b_nowrap", 32'(bus_b.RISE_CNT), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
